offchip_mem_arbiter: RTL and testbench

- Parametrised successor to the two-channel (instruction/data) off-chip refill path of the memory controller.
- Arbitrates NUM_CH cache-line requests (refill reads and dirty writebacks) onto a single off-chip memory port.
- Runs one transaction at a time and routes the response back to the owning channel.
- Sits between the i/d cache fill FSMs and the off-chip memory model/bus bridge.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_arb_grant.sv | 30 +++
 rtl/offchip_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_offchip_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the off-chip cache-line refill/writeback path:
// FSM state encodings, default line size and line geometry helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RW   = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    localparam int CACHE_LINE_SIZE = 16;

    function automatic int line_width(input int line_bytes);
        return line_bytes * 8;
    endfunction

    function automatic int offset_bits(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational winner selection: first pending channel at or after ptr,
// wrapping modulo NUM_CH. A constant-zero ptr gives fixed lowest-index priority.
module mem_arb_grant #(
    parameter int NUM_CH = 2,
    parameter int PTR_W  = 1
) (
    input  logic [NUM_CH-1:0] req_valid,
    input  logic [PTR_W-1:0]  ptr,
    output logic              grant_valid,
    output logic [PTR_W-1:0]  grant_idx,
    output logic [NUM_CH-1:0] grant_onehot
);

    always_comb begin : pick
        logic [PTR_W-1:0] idx;
        idx          = '0;
        grant_valid  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NUM_CH);
            if (!grant_valid && req_valid[idx]) begin
                grant_valid       = 1'b1;
                grant_idx         = idx;
                grant_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/offchip_mem_arbiter.sv
// Arbitrates NUM_CH cache-line refill/writeback requests onto one off-chip port,
// one transaction at a time. Define OFFCHIP_ARB_ROUND_ROBIN_EN for rotating priority.
module offchip_mem_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = CACHE_LINE_SIZE
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              req_valid,
    input  logic [NUM_CH-1:0]              req_write,
    input  logic [NUM_CH*ADDR_W-1:0]       req_addr,
    input  logic [NUM_CH*LINE_BYTES*8-1:0] req_wdata,
    output logic [NUM_CH-1:0]              req_ready,
    output logic [NUM_CH-1:0]              resp_valid,
    output logic [LINE_BYTES*8-1:0]        resp_rdata,
    output logic [ADDR_W-1:0]              offchip_mem_addr,
    output logic                           offchip_mem_read_en,
    output logic                           offchip_mem_write_en,
    output logic [LINE_BYTES*8-1:0]        offchip_mem_wdata,
    input  logic [LINE_BYTES*8-1:0]        offchip_mem_data,
    input  logic                           offchip_mem_ready,
    output logic                           offchip_mem_read_busy,
    output logic                           offchip_mem_write_busy
);

    localparam int LINE_W   = line_width(LINE_BYTES);
    localparam int OFF_BITS = offset_bits(LINE_BYTES);
    localparam int PTR_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    mem_state_e        state, state_next;
    logic [PTR_W-1:0]  ptr, owner, grant_idx;
    logic              grant_valid, is_write;
    logic [NUM_CH-1:0] grant_onehot;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q, rdata_q;

    mem_arb_grant #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_grant (
        .req_valid    (req_valid),
        .ptr          (ptr),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot)
    );

`ifdef OFFCHIP_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (state == ST_IDLE && grant_valid) begin
            ptr <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
        end
    end
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next           = state;
        req_ready            = '0;
        resp_valid           = '0;
        offchip_mem_read_en  = 1'b0;
        offchip_mem_write_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_next = ST_RW;
                end
                if (rst && grant_valid) begin
                    req_ready = grant_onehot;
                end
            end
            ST_RW: begin
                offchip_mem_read_en  = !is_write;
                offchip_mem_write_en = is_write;
                if (offchip_mem_ready) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = NUM_CH'(1) << owner;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request fields are captured once at acceptance so later req_* changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner    <= '0;
            is_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (state == ST_IDLE && grant_valid) begin
                owner    <= grant_idx;
                is_write <= req_write[grant_idx];
                addr_q   <= {req_addr[grant_idx*ADDR_W + OFF_BITS +: ADDR_W - OFF_BITS], OFF_BITS'(0)};
                wdata_q  <= req_wdata[grant_idx*LINE_W +: LINE_W];
            end
            if (state == ST_RW && offchip_mem_ready && !is_write) begin
                rdata_q <= offchip_mem_data;
            end
        end
    end

    assign offchip_mem_addr       = (state == ST_RW) ? addr_q : '0;
    assign offchip_mem_wdata      = (state == ST_RW) ? wdata_q : '0;
    assign offchip_mem_read_busy  = offchip_mem_read_en;
    assign offchip_mem_write_busy = offchip_mem_write_en;
    assign resp_rdata             = rdata_q;

endmodule

// File: tb/tb_offchip_mem_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized transactions checked against a transaction-level arbitration model.
module tb_offchip_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Default configuration: 2 channels, 16-byte lines
    logic [1:0]   req_valid = '0, req_write = '0, req_ready, resp_valid;
    logic [63:0]  req_addr = '0;
    logic [255:0] req_wdata = '0;
    logic [127:0] resp_rdata, mem_wdata, mem_data = '0;
    logic [31:0]  mem_addr;
    logic         mem_rd, mem_wr, mem_ready = 1'b0, rd_busy, wr_busy;

    // Wide configuration: 4 channels, 32-byte lines
    logic [3:0]    req_valid4 = '0, req_write4 = '0, req_ready4, resp_valid4;
    logic [127:0]  req_addr4 = '0;
    logic [1023:0] req_wdata4 = '0;
    logic [255:0]  resp_rdata4, mem_wdata4, mem_data4 = '0;
    logic [31:0]   mem_addr4;
    logic          mem_rd4, mem_wr4, mem_ready4 = 1'b0, rd_busy4, wr_busy4;

    offchip_mem_arbiter u_dut (
        .clk                    (clk),
        .rst                    (rst),
        .req_valid              (req_valid),
        .req_write              (req_write),
        .req_addr               (req_addr),
        .req_wdata              (req_wdata),
        .req_ready              (req_ready),
        .resp_valid             (resp_valid),
        .resp_rdata             (resp_rdata),
        .offchip_mem_addr       (mem_addr),
        .offchip_mem_read_en    (mem_rd),
        .offchip_mem_write_en   (mem_wr),
        .offchip_mem_wdata      (mem_wdata),
        .offchip_mem_data       (mem_data),
        .offchip_mem_ready      (mem_ready),
        .offchip_mem_read_busy  (rd_busy),
        .offchip_mem_write_busy (wr_busy)
    );

    offchip_mem_arbiter #(.NUM_CH(4), .ADDR_W(32), .LINE_BYTES(32)) u_dut4 (
        .clk                    (clk),
        .rst                    (rst),
        .req_valid              (req_valid4),
        .req_write              (req_write4),
        .req_addr               (req_addr4),
        .req_wdata              (req_wdata4),
        .req_ready              (req_ready4),
        .resp_valid             (resp_valid4),
        .resp_rdata             (resp_rdata4),
        .offchip_mem_addr       (mem_addr4),
        .offchip_mem_read_en    (mem_rd4),
        .offchip_mem_write_en   (mem_wr4),
        .offchip_mem_wdata      (mem_wdata4),
        .offchip_mem_data       (mem_data4),
        .offchip_mem_ready      (mem_ready4),
        .offchip_mem_read_busy  (rd_busy4),
        .offchip_mem_write_busy (wr_busy4)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0]   v;
        logic [1:0]   w;
        logic [31:0]  a0, a1;
        logic [127:0] wd0, wd1, rd;
        int           lat;
        int           win_fixed, win_rr;
        logic [31:0]  addr_fixed, addr_rr;
        logic [127:0] exp_wd, exp_rd;
    } vec_t;

    vec_t tbl [4];

    // Transaction-level reference state: rotating pointer and last line read
    int           ptr_m = 0;
    logic [127:0] last_rd = '0;

    localparam logic [127:0] PAT_A5   = {16{8'hA5}};
    localparam logic [127:0] PAT_DEAD = {4{32'hDEADBEEF}};
    localparam logic [127:0] PAT_BAD  = {4{32'h0BADF00D}};

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] status();
        return {mem_rd, mem_wr, rd_busy, wr_busy, resp_valid, req_ready};
    endfunction

    function automatic logic [7:0] expStatus(input bit rd, input bit wr, input logic [1:0] rv, input logic [1:0] rr);
        return {rd, wr, rd, wr, rv, rr};
    endfunction

    function automatic int pick(input logic [1:0] v, input int start);
        for (int i = 0; i < 2; i++) begin
            if (v[(start + i) % 2]) return (start + i) % 2;
        end
        return 0;
    endfunction

    // One full transaction from an IDLE cycle; lat = cycles the enable stays high.
    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] w,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [127:0] wd0, input logic [127:0] wd1, input logic [127:0] rd,
                                 input int lat, input bit hold, input int exp_win,
                                 input logic [31:0] exp_addr, input logic [127:0] exp_wd,
                                 input logic [127:0] exp_rd);
        logic [1:0] oh;
        bit wr;
        oh = 2'b01 << exp_win;
        wr = w[exp_win];
        req_valid = v;
        req_write = w;
        req_addr  = {a1, a0};
        req_wdata = {wd1, wd0};
        mem_ready = 1'b0;
        #1 checkOutput("grant", status(), expStatus(0, 0, 2'b00, oh));
        tick();
        if (!hold) begin
            req_valid = '0;
            req_write = 2'($urandom);
            req_addr  = {$urandom, $urandom};
        end
        for (int k = 0; k < lat; k++) begin
            checkOutput("rw_ctrl", status(), expStatus(!wr, wr, 2'b00, 2'b00));
            checkOutput("rw_addr", mem_addr, exp_addr);
            if (wr) checkOutput("rw_wdata", mem_wdata, exp_wd);
            if (k == lat - 1) begin
                mem_ready = 1'b1;
                mem_data  = rd;
            end
            tick();
        end
        checkOutput("resp_ctrl", status(), expStatus(0, 0, oh, 2'b00));
        checkOutput("resp_rdata", resp_rdata, exp_rd);
        mem_ready = 1'b0;
        mem_data  = {$urandom, $urandom, $urandom, $urandom};
        tick();
        checkOutput("idle_after_resp", {mem_rd, mem_wr, resp_valid}, 4'b0000);
    endtask

    task automatic runModelled(input logic [1:0] v, input logic [1:0] w,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [127:0] wd0, input logic [127:0] wd1, input logic [127:0] rd,
                               input int lat, input bit hold);
        int win;
`ifdef OFFCHIP_ARB_ROUND_ROBIN_EN
        win = pick(v, ptr_m);
        ptr_m = (win + 1) % 2;
`else
        win = pick(v, 0);
`endif
        if (!w[win]) last_rd = rd;
        applyStimulus(v, w, a0, a1, wd0, wd1, rd, lat, hold, win,
                      ((win == 1) ? a1 : a0) & 32'hFFFF_FFF0,
                      (win == 1) ? wd1 : wd0, last_rd);
    endtask

    initial begin
        tbl[0] = '{2'b10, 2'b00, 32'h0, 32'h0000_1234, '0, '0, PAT_A5, 3,
                   1, 1, 32'h0000_1230, 32'h0000_1230, '0, PAT_A5};
        tbl[1] = '{2'b01, 2'b01, 32'h8000_001F, 32'h0, PAT_DEAD, '1, {4{32'h1111_1111}}, 2,
                   0, 0, 32'h8000_0010, 32'h8000_0010, PAT_DEAD, PAT_A5};
        tbl[2] = '{2'b11, 2'b00, 32'h0000_0040, 32'h0000_005C, '0, '0, PAT_BAD, 1,
                   0, 1, 32'h0000_0040, 32'h0000_0050, '0, PAT_BAD};
        tbl[3] = '{2'b11, 2'b11, 32'hFFFF_FFFF, 32'h0000_000F, {4{32'hCAFE_0000}}, {4{32'h0000_BEEF}},
                   {4{32'h7777_7777}}, 4, 0, 0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, {4{32'hCAFE_0000}}, PAT_BAD};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ctrl", status(), 8'h00);
        checkOutput("reset_addr", mem_addr, 32'h0);
        checkOutput("reset_wdata", mem_wdata, 128'h0);
        checkOutput("reset_rdata", resp_rdata, 128'h0);
        checkOutput("reset_wide", {req_ready4, resp_valid4, mem_rd4, mem_wr4, mem_addr4}, 42'h0);
        rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
`ifdef OFFCHIP_ARB_ROUND_ROBIN_EN
            applyStimulus(tbl[i].v, tbl[i].w, tbl[i].a0, tbl[i].a1, tbl[i].wd0, tbl[i].wd1, tbl[i].rd,
                          tbl[i].lat, 1'b0, tbl[i].win_rr, tbl[i].addr_rr, tbl[i].exp_wd, tbl[i].exp_rd);
`else
            applyStimulus(tbl[i].v, tbl[i].w, tbl[i].a0, tbl[i].a1, tbl[i].wd0, tbl[i].wd1, tbl[i].rd,
                          tbl[i].lat, 1'b0, tbl[i].win_fixed, tbl[i].addr_fixed, tbl[i].exp_wd, tbl[i].exp_rd);
`endif
        end

        // Memory ready while idle must not start or complete anything
        req_valid = '0;
        mem_ready = 1'b1;
        mem_data  = {4{32'h5555_5555}};
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("idle_ready_ctrl", status(), 8'h00);
            checkOutput("idle_ready_rdata", resp_rdata, PAT_BAD);
        end
        mem_ready = 1'b0;

        // Reset in the middle of a read aborts it without a response
        req_valid = 2'b10;
        req_write = 2'b00;
        req_addr  = {32'h0000_2004, 32'h0};
        #1 checkOutput("abort_grant", status(), expStatus(0, 0, 2'b00, 2'b10));
        tick();
        checkOutput("abort_rw", status(), expStatus(1, 0, 2'b00, 2'b00));
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("abort_ctrl", status(), 8'h00);
            checkOutput("abort_addr", mem_addr, 32'h0);
        end
        rst = 1'b1;
        ptr_m   = 0;
        last_rd = '0;
        runModelled(2'b10, 2'b00, 32'h0, 32'h0000_2004, '0, '0, {4{32'h2468_ACE0}}, 3, 1'b0);

        // Both channels requesting continuously
        for (int i = 0; i < 4; i++) begin
            runModelled(2'b11, 2'(i), 32'h0000_3000 + 32'(i), 32'h0000_4008, {4{32'(i)}}, {4{32'hF0F0_0000}},
                        {4{$urandom}}, 1 + (i % 2), 1'b1);
        end

        for (int i = 0; i < 40; i++) begin
            runModelled(2'($urandom_range(1, 3)), 2'($urandom), $urandom, $urandom,
                        {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                        {$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
        end
        req_valid = '0;

        // Four-channel, 32-byte-line instance: ch2 and ch3 together, then ch3 writeback
        req_valid4 = 4'b1100;
        req_write4 = 4'b0000;
        req_addr4[64 +: 32] = 32'h0000_12FF;
        req_addr4[96 +: 32] = 32'h0000_ABCD;
        #1 checkOutput("w4_grant_rd", req_ready4, 4'b0100);
        tick();
        req_valid4 = '0;
        checkOutput("w4_rd_en", {mem_rd4, mem_wr4, rd_busy4, wr_busy4}, 4'b1010);
        checkOutput("w4_rd_addr", mem_addr4, 32'h0000_12E0);
        mem_ready4 = 1'b1;
        mem_data4  = {8{32'h1357_9BDF}};
        tick();
        checkOutput("w4_resp_rd", resp_valid4, 4'b0100);
        checkOutput("w4_rdata", resp_rdata4, {8{32'h1357_9BDF}});
        mem_ready4 = 1'b0;
        tick();
        req_valid4 = 4'b1000;
        req_write4 = 4'b1000;
        req_wdata4[768 +: 256] = {8{32'hFACE_0003}};
        req_wdata4[512 +: 256] = {8{32'h2222_2222}};
        #1 checkOutput("w4_grant_wr", req_ready4, 4'b1000);
        tick();
        req_valid4 = '0;
        checkOutput("w4_wr_en", {mem_rd4, mem_wr4, rd_busy4, wr_busy4}, 4'b0101);
        checkOutput("w4_wr_addr", mem_addr4, 32'h0000_ABC0);
        checkOutput("w4_wdata", mem_wdata4, {8{32'hFACE_0003}});
        mem_ready4 = 1'b1;
        mem_data4  = {8{32'hEEEE_EEEE}};
        tick();
        checkOutput("w4_resp_wr", resp_valid4, 4'b1000);
        checkOutput("w4_rdata_kept", resp_rdata4, {8{32'h1357_9BDF}});
        mem_ready4 = 1'b0;
        tick();
        checkOutput("w4_idle", {resp_valid4, mem_rd4, mem_wr4}, 6'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
